// File: rtl/alu.sv
//------------------------------------------------------------------------------
// Module   : alu
// Purpose  : Registered two-operand ALU (ADD/SUB/AND/OR) with carry, zero,
//            negative and signed-overflow flags, one cycle of latency.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       ALU_Sel,
    output logic [WIDTH-1:0] ALU_Out,
    output logic             Carry,
    output logic             Zero,
    output logic             Neg,
    output logic             Ovf
);

    localparam logic [1:0] c_OP_ADD = 2'b00;
    localparam logic [1:0] c_OP_SUB = 2'b01;
    localparam logic [1:0] c_OP_AND = 2'b10;
    localparam logic [1:0] c_OP_OR  = 2'b11;
    localparam int         c_MSB    = WIDTH - 1;

    // One extra bit on each side so bit WIDTH holds carry-out / borrow.
    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_diff;

    assign w_sum  = {1'b0, A} + {1'b0, B};
    assign w_diff = {1'b0, A} - {1'b0, B};

    logic [WIDTH-1:0] res_d,   res_q;
    logic             carry_d, carry_q;
    logic             zero_d,  zero_q;
    logic             neg_d,   neg_q;
    logic             ovf_d,   ovf_q;

    always_comb begin
        res_d   = w_sum[WIDTH-1:0];
        carry_d = w_sum[WIDTH];
        ovf_d   = (A[c_MSB] == B[c_MSB]) && (w_sum[c_MSB] != A[c_MSB]);
        case (ALU_Sel)
            c_OP_ADD: begin
                res_d   = w_sum[WIDTH-1:0];
                carry_d = w_sum[WIDTH];
                ovf_d   = (A[c_MSB] == B[c_MSB]) && (w_sum[c_MSB] != A[c_MSB]);
            end
            c_OP_SUB: begin
                res_d   = w_diff[WIDTH-1:0];
                carry_d = w_diff[WIDTH];
                ovf_d   = (A[c_MSB] != B[c_MSB]) && (w_diff[c_MSB] != A[c_MSB]);
            end
            c_OP_AND: begin
                res_d   = A & B;
                carry_d = 1'b0;
                ovf_d   = 1'b0;
            end
            c_OP_OR: begin
                res_d   = A | B;
                carry_d = 1'b0;
                ovf_d   = 1'b0;
            end
            // Unresolved selects fall back to the ADD datapath set above.
            default: begin
                res_d   = w_sum[WIDTH-1:0];
                carry_d = w_sum[WIDTH];
                ovf_d   = (A[c_MSB] == B[c_MSB]) && (w_sum[c_MSB] != A[c_MSB]);
            end
        endcase
        zero_d = (res_d == '0);
        neg_d  = res_d[c_MSB];
    end

    // Reset state reports a zero result, so Zero is the only flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b1;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            res_q   <= res_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ALU_Out = res_q;
    assign Carry   = carry_q;
    assign Zero    = zero_q;
    assign Neg     = neg_q;
    assign Ovf     = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_alu.sv
//------------------------------------------------------------------------------
// Module   : tb_alu
// Purpose  : Scoreboard bench for alu: random and directed operations checked
//            against an arithmetic reference model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu;

    localparam int WIDTH = 16;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             carry;
        logic             zero;
        logic             neg;
        logic             ovf;
    } exp_t;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [1:0]       ALU_Sel;
    logic [WIDTH-1:0] ALU_Out;
    logic             Carry;
    logic             Zero;
    logic             Neg;
    logic             Ovf;

    int   n_vec;
    int   n_bad;
    exp_t sb_q[$];

    alu #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .A       (A),
        .B       (B),
        .ALU_Sel (ALU_Sel),
        .ALU_Out (ALU_Out),
        .Carry   (Carry),
        .Zero    (Zero),
        .Neg     (Neg),
        .Ovf     (Ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: integer arithmetic on unsigned and signed views.
    function automatic exp_t model(input int unsigned a, input int unsigned b, input int sel);
        exp_t        e;
        int          sa;
        int          sb;
        int          sr;
        int unsigned r;
        sa = (a >= 32768) ? int'(a) - 65536 : int'(a);
        sb = (b >= 32768) ? int'(b) - 65536 : int'(b);
        e.carry = 1'b0;
        e.ovf   = 1'b0;
        case (sel)
            0: begin
                r       = a + b;
                sr      = sa + sb;
                e.carry = (r >= 65536);
                e.ovf   = (sr > 32767) || (sr < -32768);
            end
            1: begin
                r       = (a + 65536 - b) % 65536;
                sr      = sa - sb;
                e.carry = (a < b);
                e.ovf   = (sr > 32767) || (sr < -32768);
            end
            2:       r = a & b;
            default: r = a | b;
        endcase
        r      = r % 65536;
        e.res  = r[WIDTH-1:0];
        e.zero = (r == 0);
        e.neg  = (r >= 32768);
        return e;
    endfunction

    task automatic check(input string name, input exp_t e);
        n_vec++;
        if (ALU_Out !== e.res || Carry !== e.carry || Zero !== e.zero ||
            Neg !== e.neg || Ovf !== e.ovf) begin
            n_bad++;
            $display("FAIL %s: got out=%h c=%b z=%b n=%b v=%b, want out=%h c=%b z=%b n=%b v=%b",
                     name, ALU_Out, Carry, Zero, Neg, Ovf,
                     e.res, e.carry, e.zero, e.neg, e.ovf);
        end
    endtask

    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [1:0] s);
        @(negedge clk);
        A       = a;
        B       = b;
        ALU_Sel = s;
        sb_q.push_back(model(int'(a), int'(b), int'(s)));
    endtask

    exp_t rst_exp;
    assign rst_exp = '{res: '0, carry: 1'b0, zero: 1'b1, neg: 1'b0, ovf: 1'b0};

    // Monitor: one result per clock after the capturing edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("result", e);
            end
        end
    end

    initial begin
        n_vec   = 0;
        n_bad   = 0;
        rst     = 1'b1;
        A       = 16'h1234;
        B       = 16'h4321;
        ALU_Sel = 2'b00;
        #2;
        check("reset_async", rst_exp);
        @(posedge clk);
        #1;
        check("reset_hold", rst_exp);
        @(negedge clk);
        rst = 1'b0;

        issue(16'h00FA, 16'h0002, 2'b00);
        issue(16'h00FA, 16'h0002, 2'b01);
        issue(16'h00FA, 16'h0002, 2'b10);
        issue(16'h00FA, 16'h0002, 2'b11);
        issue(16'h00FA, 16'h0002, 2'b00);
        issue(16'h7FFF, 16'h0001, 2'b00);
        issue(16'h0000, 16'h0001, 2'b01);
        issue(16'hFFFF, 16'h0001, 2'b00);
        issue(16'h00F0, 16'h000F, 2'b10);
        issue(16'h8000, 16'h0001, 2'b01);
        issue(16'h8000, 16'h8000, 2'b00);
        issue(16'h1234, 16'h1234, 2'b01);

        // Asynchronous reset pulse between edges while 0x00FC is held.
        issue(16'h00FA, 16'h0002, 2'b00);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("reset_mid", rst_exp);
        #1;
        rst = 1'b0;
        issue(16'h0005, 16'h0003, 2'b01);

        for (int i = 0; i < 300; i++) begin
            issue(16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)));
        end

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        #2;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d results outstanding, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
